// File: rtl/store_write_buffer_if.sv
// Store/load request bus plus the data-memory port of the store write buffer.
interface store_write_buffer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [3:0]        st_be;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic              empty;
    logic              mem_we;
    logic [31:0]       mem_address;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport master (
        output st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, mem_read_data,
        input  st_ready, ld_data, empty, mem_we, mem_address, mem_write_data
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, mem_read_data,
        output st_ready, ld_data, empty, mem_we, mem_address, mem_write_data
    );
endinterface

// File: rtl/store_write_buffer.sv
// Store write buffer: queues byte-masked stores, coalesces back-to-back
// stores to the same word, drains one entry per idle memory cycle with a
// read-merge-write, and forwards pending bytes to loads.
module store_write_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    store_write_buffer_if.slave  bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WA_W  = ADDR_W - 2;

    logic [WA_W-1:0]  ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [3:0]       ent_mask [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] yng;
    logic [CNT_W-1:0] count;

    logic [WA_W-1:0]  st_word;
    logic [WA_W-1:0]  ld_word;
    logic             full;
    logic             accept;
    logic             drain;
    logic             coalesce;
    logic             alloc;
    logic [PTR_W-1:0] fwd_idx;
    logic [3:0]       unused_lsbs;

    assign st_word     = bus.st_addr[ADDR_W-1:2];
    assign ld_word     = bus.ld_addr[ADDR_W-1:2];
    assign unused_lsbs = {bus.st_addr[1:0], bus.ld_addr[1:0]};
    assign yng         = tail - PTR_W'(1);
    assign full        = (count == CNT_W'(DEPTH));

    assign bus.st_ready = !reset && !full;
    assign bus.empty    = reset || (count == '0);

    // A zero byte-enable store is accepted by the handshake but changes nothing.
    assign accept = bus.st_valid && !reset && !full && (bus.st_be != '0);
    assign drain  = !reset && !bus.ld_valid && (count != '0);

    // The youngest entry is the one draining only when it is the sole entry.
    assign coalesce = accept && (count != '0) && (ent_addr[yng] == st_word)
                      && !(drain && (count == CNT_W'(1)));
    assign alloc    = accept && !coalesce;

    // Memory port: loads own the port, otherwise drain head with merged bytes.
    always_comb begin
        bus.mem_we         = drain;
        bus.mem_address    = bus.ld_valid ? 32'({ld_word, 2'b00})
                                          : 32'({ent_addr[head], 2'b00});
        bus.mem_write_data = bus.mem_read_data;
        for (int unsigned l = 0; l < 4; l++) begin
            if (ent_mask[head][l])
                bus.mem_write_data[8*l +: 8] = ent_data[head][8*l +: 8];
        end
    end

    // Load forwarding: walk oldest to youngest so the youngest matching byte wins.
    always_comb begin
        bus.ld_data = bus.mem_read_data;
        fwd_idx     = head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (ent_addr[fwd_idx] == ld_word)) begin
                for (int unsigned l = 0; l < 4; l++) begin
                    if (ent_mask[fwd_idx][l])
                        bus.ld_data[8*l +: 8] = ent_data[fwd_idx][8*l +: 8];
                end
            end
        end
    end

    // FIFO state: allocate or coalesce at the tail, retire at the head.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                ent_mask[i] <= '0;
        end else begin
            if (drain)
                head <= head + PTR_W'(1);
            if (alloc) begin
                ent_addr[tail] <= st_word;
                ent_data[tail] <= bus.st_data;
                ent_mask[tail] <= bus.st_be;
                tail           <= tail + PTR_W'(1);
            end
            if (coalesce) begin
                for (int unsigned l = 0; l < 4; l++) begin
                    if (bus.st_be[l])
                        ent_data[yng][8*l +: 8] <= bus.st_data[8*l +: 8];
                end
                ent_mask[yng] <= ent_mask[yng] | bus.st_be;
            end
            count <= count + CNT_W'(alloc) - CNT_W'(drain);
        end
    end
endmodule
